hcsr04_emulador: RTL and testbench

Behavioural/synthesizable model of the HC-SR04 ultrasonic sensor: the responder side of the trigger/echo protocol driven by interface_hcsr04. It accepts a valid trigger pulse, waits a fixed transducer delay, then drives an echo pulse whose width encodes a programmable distance in cm. It is used as the sensor stand-in in system benches and in FPGA loopback tests (trigger pin looped to echo input), on the same 50 MHz clock.

---
 rtl/hcsr04_emulador.sv | 151 +++++++++++++++
 tb/tb_hcsr04_emulador.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hcsr04_emulador.sv
// HC-SR04 responder: accepts a trigger pulse of at least MIN_TRIGGER cycles,
// waits ATRASO cycles, then drives an echo whose width encodes distancia (cm).
//
// state         | code | meaning
// st_inicial    | 0    | one cycle after reset release
// st_espera     | 1    | idle, armed once trigger has been seen low
// st_mede       | 2    | trigger high, counting its width
// st_atraso     | 3    | transducer delay before echo rises
// st_echo_alto  | 4    | echo high, counting down the encoded width
// st_holdoff    | 5    | post-echo dead time, triggers ignored
module hcsr04_emulador #(
  parameter int MIN_TRIGGER   = 500,
  parameter int ATRASO        = 20000,
  parameter int CICLOS_POR_CM = 2941,
  parameter int DIST_MAX      = 400,
  parameter int TIMEOUT       = 1900000,
  parameter int HOLDOFF       = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia,
  output logic       echo,
  output logic       ocupado,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    st_inicial   = 4'h0,
    st_espera    = 4'h1,
    st_mede      = 4'h2,
    st_atraso    = 4'h3,
    st_echo_alto = 4'h4,
    st_holdoff   = 4'h5
  } estado_t;

  localparam logic [21:0] MIN_C      = 22'(MIN_TRIGGER);
  localparam logic [21:0] ATRASO_FIM = 22'(ATRASO - 1);
  localparam logic [21:0] CPC_C      = 22'(CICLOS_POR_CM);
  localparam logic [21:0] TIMEOUT_C  = 22'(TIMEOUT);
  localparam logic [21:0] HOLDOFF_C  = 22'(HOLDOFF);
  localparam logic [8:0]  DIST_MAX_C = 9'(DIST_MAX);

  estado_t     estado_q, estado_d;
  logic [21:0] cnt_q, cnt_d;
  logic [8:0]  dist_q, dist_d;
  logic        echo_q, echo_d;
  logic        ocupado_q, ocupado_d;
  logic        trig_prev_q, trig_prev_d;
  logic [21:0] largura;

  // Next-state and next-output logic; one shared counter serves every timed state.
  always_comb begin
    estado_d    = estado_q;
    cnt_d       = cnt_q;
    dist_d      = dist_q;
    echo_d      = echo_q;
    ocupado_d   = ocupado_q;
    trig_prev_d = trigger;
    // Out-of-range or zero distance reports the sensor's no-echo timeout width.
    if (dist_q == 9'd0 || dist_q > DIST_MAX_C)
      largura = TIMEOUT_C;
    else
      largura = 22'(dist_q) * CPC_C;

    case (estado_q)
      st_inicial: begin
        estado_d  = st_espera;
        echo_d    = 1'b0;
        ocupado_d = 1'b0;
        cnt_d     = '0;
      end
      st_espera: begin
        // Require a rising edge so a trigger stuck high never starts a measurement.
        if (trigger && !trig_prev_q) begin
          estado_d = st_mede;
          cnt_d    = 22'd1;
        end
      end
      st_mede: begin
        if (trigger) begin
          if (cnt_q < MIN_C) cnt_d = cnt_q + 22'd1;
        end else if (cnt_q >= MIN_C) begin
          estado_d  = st_atraso;
          dist_d    = distancia;
          ocupado_d = 1'b1;
          cnt_d     = '0;
        end else begin
          estado_d = st_espera;
        end
      end
      st_atraso: begin
        if (cnt_q == ATRASO_FIM) begin
          estado_d = st_echo_alto;
          echo_d   = 1'b1;
          cnt_d    = largura;
        end else begin
          cnt_d = cnt_q + 22'd1;
        end
      end
      st_echo_alto: begin
        if (cnt_q <= 22'd1) begin
          estado_d = st_holdoff;
          echo_d   = 1'b0;
          cnt_d    = HOLDOFF_C;
        end else begin
          cnt_d = cnt_q - 22'd1;
        end
      end
      st_holdoff: begin
        if (cnt_q <= 22'd1) begin
          estado_d  = st_espera;
          ocupado_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q - 22'd1;
        end
      end
      default: begin
        estado_d  = st_inicial;
        echo_d    = 1'b0;
        ocupado_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset drops echo immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= st_inicial;
      cnt_q       <= '0;
      dist_q      <= '0;
      echo_q      <= 1'b0;
      ocupado_q   <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      dist_q      <= dist_d;
      echo_q      <= echo_d;
      ocupado_q   <= ocupado_d;
      trig_prev_q <= trig_prev_d;
    end
  end

  assign echo      = echo_q;
  assign ocupado   = ocupado_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_hcsr04_emulador.sv
// Bench for hcsr04_emulador with shortened timing parameters: a time-based
// model predicts echo/ocupado/db_estado every cycle, and observed pulse
// widths and latencies are pinned against hand-computed values.
module tb_hcsr04_emulador;

  localparam int MIN_T = 8;
  localparam int ATR   = 40;
  localparam int CPC   = 3;
  localparam int DMAX  = 400;
  localparam int TMO   = 1500;
  localparam int HOLD  = 60;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       trigger = 1'b0;
  logic [8:0] distancia = '0;
  logic       echo;
  logic       ocupado;
  logic [3:0] db_estado;

  int n_cmp = 0;
  int n_mis = 0;

  hcsr04_emulador #(
    .MIN_TRIGGER(MIN_T), .ATRASO(ATR), .CICLOS_POR_CM(CPC),
    .DIST_MAX(DMAX), .TIMEOUT(TMO), .HOLDOFF(HOLD)
  ) dut (
    .clock(clock), .reset(reset), .trigger(trigger), .distancia(distancia),
    .echo(echo), .ocupado(ocupado), .db_estado(db_estado)
  );

  always #10 clock = ~clock;

  int ec = 0;
  always @(posedge clock) ec <= ec + 1;

  // Reference model: times of acceptance, echo rise/fall and end of busy.
  int m_cyc = 0, m_free = 0, m_acc = 0, m_rise = 0, m_fall = 0, m_high = 0, m_w = 0;
  bit m_pulse = 0, m_have = 0, m_prev = 0;
  bit exp_echo = 0, exp_ocup = 0;
  int exp_st = 0;

  always begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_cyc = 0; m_pulse = 0; m_have = 0; m_prev = 0;
      exp_echo = 0; exp_ocup = 0; exp_st = 0;
    end else begin
      m_cyc++;
      if (m_cyc == 1) m_free = 1;
      else if (m_cyc > m_free) begin
        if (m_pulse) begin
          if (trigger) m_high++;
          else begin
            m_pulse = 0;
            if (m_high >= MIN_T) begin
              m_have = 1;
              m_acc  = m_cyc;
              m_w    = (distancia == 0 || int'(distancia) > DMAX) ? TMO : int'(distancia) * CPC;
              m_rise = m_acc + ATR;
              m_fall = m_rise + m_w;
              m_free = m_fall + HOLD;
            end else m_free = m_cyc;
          end
        end else if (trigger && !m_prev) begin
          m_pulse = 1;
          m_high  = 1;
        end
      end
      m_prev   = trigger;
      exp_echo = m_have && m_cyc >= m_rise && m_cyc < m_fall;
      exp_ocup = m_have && m_cyc >= m_acc && m_cyc < m_free;
      if (m_pulse) exp_st = 2;
      else if (!m_have || m_cyc >= m_free) exp_st = 1;
      else if (m_cyc < m_rise) exp_st = 3;
      else if (m_cyc < m_fall) exp_st = 4;
      else exp_st = 5;
    end
  end

  // Stimulus-owned bookkeeping read by the monitor.
  bit pin_mode = 0;
  bit done = 0;
  int acc_fall_ec = 0;
  int timeouts = 0;
  int exp_w[64];
  int wr_idx = 0;

  // Monitor: every comparison in the bench is made and counted here.
  bit echo_p = 0, ocup_p = 0, done_seen = 0;
  int echo_rise_ec = 0, echo_fall_ec = 0, rd_idx = 0, w_obs = 0;

  always begin
    @(negedge clock or posedge reset);
    #1;
    n_cmp++;
    if (echo !== exp_echo || ocupado !== exp_ocup || db_estado !== 4'(exp_st)) begin
      n_mis++;
      if (n_mis <= 20)
        $display("FAIL cycle t=%0t echo=%b want %b ocupado=%b want %b db_estado=%0d want %0d",
                 $time, echo, exp_echo, ocupado, exp_ocup, db_estado, exp_st);
    end
    if (pin_mode && !reset) begin
      if (ocupado && !ocup_p) begin
        n_cmp++;
        if (ec != acc_fall_ec) begin
          n_mis++;
          $display("FAIL ocupado_rise edge=%0d want %0d", ec, acc_fall_ec);
        end
      end
      if (echo && !echo_p) begin
        n_cmp++;
        if (ec - acc_fall_ec != ATR) begin
          n_mis++;
          $display("FAIL echo_latency got %0d want %0d", ec - acc_fall_ec, ATR);
        end
      end
      if (!echo && echo_p) begin
        w_obs = ec - echo_rise_ec;
        n_cmp++;
        if (rd_idx >= wr_idx) begin
          n_mis++;
          $display("FAIL echo_width unexpected echo of %0d cycles, want none", w_obs);
        end else begin
          if (w_obs != exp_w[rd_idx]) begin
            n_mis++;
            $display("FAIL echo_width got %0d want %0d", w_obs, exp_w[rd_idx]);
          end
          rd_idx++;
        end
      end
      if (!ocupado && ocup_p) begin
        n_cmp++;
        if (ec - echo_fall_ec != HOLD) begin
          n_mis++;
          $display("FAIL holdoff got %0d want %0d", ec - echo_fall_ec, HOLD);
        end
      end
    end
    if (echo && !echo_p) echo_rise_ec = ec;
    if (!echo && echo_p) echo_fall_ec = ec;
    echo_p = echo;
    ocup_p = ocupado;
    if (done && !done_seen) begin
      done_seen = 1;
      n_cmp++;
      if (rd_idx != wr_idx) begin
        n_mis++;
        $display("FAIL echo_count got %0d want %0d", rd_idx, wr_idx);
      end
      n_cmp++;
      if (timeouts != 0) begin
        n_mis++;
        $display("FAIL wait_bound expired %0d want 0", timeouts);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse(input int n, input int d);
    distancia = 9'(d);
    trigger = 1'b1;
    cyc(n);
    trigger = 1'b0;
    acc_fall_ec = ec + 1;
  endtask

  task automatic raw(input int n);
    trigger = 1'b1;
    cyc(n);
    trigger = 1'b0;
  endtask

  task automatic expect_w(input int w);
    exp_w[wr_idx] = w;
    wr_idx++;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    cyc(2);
    while (!(db_estado == 4'h1 && !ocupado) && k < 5000) begin
      cyc(1);
      k++;
    end
    if (k >= 5000) timeouts++;
  endtask

  task automatic wait_level(input logic lv);
    int k;
    k = 0;
    while (echo !== lv && k < 3000) begin
      cyc(1);
      k++;
    end
    if (k >= 3000) timeouts++;
  endtask

  initial begin
    #1 reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(3);
    pin_mode = 1;

    expect_w(30);   pulse(8, 10);  wait_idle(); cyc(3);
    pulse(7, 10);   wait_idle();   cyc(2);
    expect_w(75);   pulse(8, 25);  wait_idle();
    expect_w(1500); pulse(8, 0);   wait_idle();
    expect_w(1500); pulse(8, 401); wait_idle();
    expect_w(1200); pulse(8, 400); wait_idle();
    expect_w(3);    pulse(8, 1);   wait_idle();

    // Triggers during delay and holdoff, distance change mid-echo: all ignored.
    expect_w(45); pulse(8, 15);
    cyc(5); raw(10);
    wait_level(1'b1); cyc(10); distancia = 9'd26;
    wait_level(1'b0); cyc(5); raw(10);
    wait_idle();

    // Trigger raised in holdoff and still high after it ends: no new measurement.
    expect_w(30); pulse(8, 10);
    wait_level(1'b1); wait_level(1'b0); cyc(20);
    trigger = 1'b1; cyc(100); trigger = 1'b0; cyc(5);
    wait_idle();

    // Long trigger is accepted on its falling edge.
    expect_w(60); pulse(200, 20); wait_idle();

    pin_mode = 0;
    for (int i = 0; i < 1500; i++) begin
      trigger = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0) distancia = 9'($urandom_range(0, 511));
        else distancia = 9'($urandom_range(0, 60));
      end
      cyc($urandom_range(1, 14));
    end
    trigger = 1'b0;
    wait_idle();

    // Reset in the middle of an echo drops everything at once.
    pulse(8, 10);
    wait_level(1'b1); cyc(5);
    #2 reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(3);
    pin_mode = 1;
    expect_w(30); pulse(8, 10); wait_idle();

    done = 1;
    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
